// File: rtl/exec_unit_if.sv
// Execute-stage bus: operation request handshake plus writeback/flag outputs.
// The master drives requests; the execute unit is the slave.
interface exec_unit_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            rd_in;
    logic                  wrEn;
    logic [2:0]            wr_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  zero;
    logic                  carry;
    logic                  busy;

    modport master (
        output in_valid, op, a, b, rd_in,
        input  in_ready, wrEn, wr_rd, wr_data, zero, carry, busy
    );

    modport slave (
        input  in_valid, op, a, b, rd_in,
        output in_ready, wrEn, wr_rd, wr_data, zero, carry, busy
    );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ADD/SUB/logic/shift, iterative shift-add MUL,
// registered writeback pulse and zero/carry flags.
module exec_unit #(
    parameter int DATA_WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    exec_unit_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
    } op_t;

    state_t state, state_nx;
    op_t    op_v;

    logic                    accept;
    logic                    mul_last;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [2*DATA_WIDTH-1:0] acc_nx;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [CW-1:0]           cnt;
    logic [2:0]              rd_q;
    logic [2:0]              amt;
    logic [DATA_WIDTH:0]     wide;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_c;

    assign op_v     = op_t'(bus.op);
    assign amt      = bus.b[2:0];
    assign accept   = bus.in_valid && (state == S_IDLE);
    assign mul_last = (state == S_MUL) && (cnt == CW'(DATA_WIDTH - 1));
    assign acc_nx   = acc + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && op_v == OP_MUL) state_nx = S_MUL;
            S_MUL:  if (mul_last)                 state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        case (state)
            S_IDLE:  bus.in_ready = 1'b1;
            S_MUL:   bus.busy     = 1'b1;
            default: bus.in_ready = 1'b1;
        endcase
    end

    // Shifts go through a one-bit-wider word so the last bit shifted out
    // lands in a fixed position and is naturally 0 for a zero amount.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_v)
            OP_ADD: begin
                wide    = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res = wide[DATA_WIDTH-1:0];
                alu_c   = wide[DATA_WIDTH];
            end
            OP_SUB: begin
                wide    = {1'b0, bus.a} - {1'b0, bus.b};
                alu_res = wide[DATA_WIDTH-1:0];
                alu_c   = wide[DATA_WIDTH];
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SHL: begin
                wide    = {1'b0, bus.a} << amt;
                alu_res = wide[DATA_WIDTH-1:0];
                alu_c   = wide[DATA_WIDTH];
            end
            OP_SHR: begin
                wide    = {bus.a, 1'b0} >> amt;
                alu_res = wide[DATA_WIDTH:1];
                alu_c   = wide[0];
            end
            default: ;
        endcase
    end

    // Datapath and writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wrEn    <= 1'b0;
            bus.wr_rd   <= '0;
            bus.wr_data <= '0;
            bus.zero    <= 1'b0;
            bus.carry   <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            rd_q        <= '0;
        end else begin
            bus.wrEn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_v == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{DATA_WIDTH{1'b0}}, bus.a};
                            mplier <= bus.b;
                            cnt    <= '0;
                            rd_q   <= bus.rd_in;
                        end else begin
                            bus.wrEn    <= (bus.rd_in != 3'd0);
                            bus.wr_rd   <= bus.rd_in;
                            bus.wr_data <= alu_res;
                            bus.zero    <= (alu_res == '0);
                            bus.carry   <= alu_c;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Final iteration's partial product is folded in via acc_nx
                    if (mul_last) begin
                        bus.wrEn    <= (rd_q != 3'd0);
                        bus.wr_rd   <= rd_q;
                        bus.wr_data <= acc_nx[DATA_WIDTH-1:0];
                        bus.zero    <= (acc_nx[DATA_WIDTH-1:0] == '0);
                        bus.carry   <= (acc_nx[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected writebacks,
// a negedge monitor pops and compares on every wrEn pulse.
module tb_exec_unit;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b100,
                           SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    exec_unit_if #(.DATA_WIDTH(8)) bus ();
    exec_unit #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] r);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.rd_in    = r;
        bus.in_valid = 1'b1;
    endtask

    task automatic push(input logic [2:0] r, input logic [7:0] d, input logic z, input logic c);
        exp_t e;
        e.rd = r; e.data = d; e.z = z; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wrEn"},     bus.wrEn,     0);
        chk({tag, "_wr_rd"},    bus.wr_rd,    0);
        chk({tag, "_wr_data"},  bus.wr_data,  0);
        chk({tag, "_zero"},     bus.zero,     0);
        chk({tag, "_carry"},    bus.carry,    0);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    // Monitor: every writeback pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && bus.wrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wrEn: got wr_rd=%0d wr_data=%0h expected no write",
                         bus.wr_rd, bus.wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd",    bus.wr_rd,   e.rd);
                chk("wb_data",  bus.wr_data, e.data);
                chk("wb_zero",  bus.zero,    e.z);
                chk("wb_carry", bus.carry,   e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
        #1 rst = 1'b1;
        #2 chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // ADD with carry-out
        @(negedge clk) drive(ADD, 8'hF0, 8'h20, 3'd3); push(3'd3, 8'h10, 1'b0, 1'b1);
        @(negedge clk) bus.in_valid = 1'b0;
        @(negedge clk) chk("t1_wrEn_low", bus.wrEn, 0);

        // Back-to-back SUB (borrow) and XOR (zero)
        @(negedge clk) drive(SUB, 8'h05, 8'h07, 3'd1); push(3'd1, 8'hFE, 1'b0, 1'b1);
        chk("t2_ready0", bus.in_ready, 1);
        @(negedge clk) drive(XOR, 8'h5A, 8'h5A, 3'd2); push(3'd2, 8'h00, 1'b1, 1'b0);
        chk("t2_ready1", bus.in_ready, 1);
        @(negedge clk) bus.in_valid = 1'b0;
        chk("t2_ready2", bus.in_ready, 1);
        @(negedge clk) chk("t2_ready3", bus.in_ready, 1);

        // MUL 0x13*0x0D, with an ignored ADD during the busy window
        @(negedge clk) drive(MUL, 8'h13, 8'h0D, 3'd4); push(3'd4, 8'hF7, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus.in_valid = 1'b0;
            if (i == 3) drive(ADD, 8'h01, 8'h02, 3'd3);
            if (i == 4) bus.in_valid = 1'b0;
            chk("t3_ready_busy", bus.in_ready, 0);
            chk("t3_busy", bus.busy, 1);
        end
        @(negedge clk);
        chk("t3_wrEn", bus.wrEn, 1);
        chk("t3_ready_done", bus.in_ready, 1);
        chk("t3_busy_done", bus.busy, 0);

        // MUL overflow to zero, then SHL accepted in the writeback cycle
        @(negedge clk) drive(MUL, 8'h20, 8'h10, 3'd5); push(3'd5, 8'h00, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t4_wrEn", bus.wrEn, 1);
        chk("t4_ready", bus.in_ready, 1);
        drive(SHL, 8'h81, 8'h01, 3'd7); push(3'd7, 8'h02, 1'b0, 1'b1);
        @(negedge clk) bus.in_valid = 1'b0;
        chk("t4_shl_no_busy", bus.busy, 0);

        // SHR by zero, then rd=0 writes suppressed but flags/data update
        @(negedge clk) drive(SHR, 8'h80, 8'h00, 3'd6); push(3'd6, 8'h80, 1'b0, 1'b0);
        @(negedge clk) drive(ADD, 8'h01, 8'h01, 3'd0);
        @(negedge clk) bus.in_valid = 1'b0;
        chk("t5_rd0_wrEn", bus.wrEn, 0);
        chk("t5_rd0_data", bus.wr_data, 8'h02);
        chk("t5_rd0_zero", bus.zero, 0);
        chk("t5_rd0_carry", bus.carry, 0);
        @(negedge clk) drive(ADD, 8'hFF, 8'h01, 3'd0);
        @(negedge clk) bus.in_valid = 1'b0;
        chk("t5b_wrEn", bus.wrEn, 0);
        chk("t5b_wr_rd", bus.wr_rd, 0);
        chk("t5b_data", bus.wr_data, 8'h00);
        chk("t5b_zero", bus.zero, 1);
        chk("t5b_carry", bus.carry, 1);

        // Async reset during MUL iteration 4
        @(negedge clk) drive(MUL, 8'h13, 8'h0D, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.in_valid = 1'b0;
        end
        chk("t6_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t6_abort");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", bus.in_ready, 1);
        chk("t6_busy_after", bus.busy, 0);
        repeat (12) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
